line_buffer_5x5: RTL and testbench

Upstream feeder for the 5x5 window buffer stage. Accepts a raster pixel stream, stores the previous four image rows, and emits five vertically aligned pixels of the current column (rows r-4..r) per accepted pixel. The downstream window buffer shifts these column vectors into its 5x5 register array. The block also produces the per-frame done pulse that starts the window controller.

---
 rtl/line_buffer_5x5_if.sv | 37 +++
 rtl/line_buffer_5x5.sv | 146 ++++++++++++++
 tb/tb_line_buffer_5x5.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/line_buffer_5x5_if.sv
// Pixel-stream bundle between the raster source, the line buffer and the
// downstream 5x5 window buffer.
//   i_valid/i_data             : raster pixel stream into the line buffer
//   o_tap0..o_tap4             : column vector, rows r..r-4 of column c
//   o_valid/o_col/o_row/o_done : tap qualifier, tap position, end-of-frame pulse
// The line buffer connects through the slave modport; the pixel source and
// the window buffer sit on the master side.
interface line_buffer_5x5_if #(
  parameter int DATA_WIDTH = 8,
  parameter int COLS       = 640,
  parameter int ROWS       = 480
);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);

  logic                  i_valid;
  logic [DATA_WIDTH-1:0] i_data;
  logic [DATA_WIDTH-1:0] o_tap0;
  logic [DATA_WIDTH-1:0] o_tap1;
  logic [DATA_WIDTH-1:0] o_tap2;
  logic [DATA_WIDTH-1:0] o_tap3;
  logic [DATA_WIDTH-1:0] o_tap4;
  logic                  o_valid;
  logic [CW-1:0]         o_col;
  logic [RW-1:0]         o_row;
  logic                  o_done;

  modport master (
    output i_valid, i_data,
    input  o_tap0, o_tap1, o_tap2, o_tap3, o_tap4, o_valid, o_col, o_row, o_done
  );

  modport slave (
    input  i_valid, i_data,
    output o_tap0, o_tap1, o_tap2, o_tap3, o_tap4, o_valid, o_col, o_row, o_done
  );
endinterface

// File: rtl/line_buffer_5x5.sv
// Four-line raster buffer feeding the 5x5 window buffer. Every accepted pixel
// produces, one cycle later, the five vertically aligned pixels of its column
// (rows r..r-4) plus its position; o_done pulses once per completed frame.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : line_buffer_5x5_if.slave (pixel input, taps, position, valid, done)
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for pixel (0,0) of a frame
// FILL   | rows 0..3 being stored, taps incomplete, o_valid held low
// STREAM | rows 4..ROWS-1, every accepted pixel yields a valid column
// DONE   | one cycle after the last pixel; raises o_done next cycle
module line_buffer_5x5 #(
  parameter int DATA_WIDTH = 8,
  parameter int COLS       = 640,
  parameter int ROWS       = 480
) (
  input logic             clk,
  input logic             rst,
  line_buffer_5x5_if.slave bus
);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_STREAM = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         col_q, col_d;
  logic [RW-1:0]         row_q, row_d;
  logic [DATA_WIDTH-1:0] tap_q [5];
  logic [DATA_WIDTH-1:0] tap_d [5];
  logic                  valid_q, valid_d;
  logic                  done_q, done_d;

  // Line memories: line_q[0] holds row r-1, line_q[3] holds row r-4.
  // Not reset; o_valid is gated by the row count so stale data never escapes.
  logic [DATA_WIDTH-1:0] line_q [4][COLS];

  logic accept;
  logic col_last;
  logic row_last;

  assign accept   = bus.i_valid;
  assign col_last = (col_q == CW'(COLS - 1));
  assign row_last = (row_q == RW'(ROWS - 1));

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = ST_FILL;
      ST_FILL:   if (accept && col_last && (row_q == RW'(3))) state_d = ST_STREAM;
      ST_STREAM: if (accept && col_last && row_last) state_d = ST_DONE;
      // A pixel arriving in DONE is (0,0) of the next frame.
      ST_DONE:   state_d = accept ? ST_FILL : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    valid_d = accept && (row_q >= RW'(4));
    done_d  = (state_q == ST_DONE);
    for (int k = 0; k < 5; k++) tap_d[k] = tap_q[k];
    if (accept) begin
      tap_d[0] = bus.i_data;
      for (int k = 1; k < 5; k++) tap_d[k] = line_q[k-1][col_q];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      for (int k = 0; k < 5; k++) tap_q[k] <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      for (int k = 0; k < 5; k++) tap_q[k] <= tap_d[k];
    end
  end

  // Read-before-write: each line takes the old value of the line above it.
  always_ff @(posedge clk) begin
    if (accept) begin
      line_q[0][col_q] <= bus.i_data;
      for (int k = 1; k < 4; k++) line_q[k][col_q] <= line_q[k-1][col_q];
    end
  end

  assign bus.o_tap0  = tap_q[0];
  assign bus.o_tap1  = tap_q[1];
  assign bus.o_tap2  = tap_q[2];
  assign bus.o_tap3  = tap_q[3];
  assign bus.o_tap4  = tap_q[4];
  assign bus.o_valid = valid_q;
  assign bus.o_col   = col_q_out();
  assign bus.o_row   = row_q_out();
  assign bus.o_done  = done_q;

  // Position of the emitted taps is registered alongside them.
  logic [CW-1:0] ocol_q;
  logic [RW-1:0] orow_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ocol_q <= '0;
      orow_q <= '0;
    end else if (accept) begin
      ocol_q <= col_q;
      orow_q <= row_q;
    end
  end

  function automatic logic [CW-1:0] col_q_out();
    return ocol_q;
  endfunction

  function automatic logic [RW-1:0] row_q_out();
    return orow_q;
  endfunction
endmodule

// File: tb/tb_line_buffer_5x5.sv
module tb_line_buffer_5x5;
  localparam int DW   = 8;
  localparam int COLS = 8;
  localparam int ROWS = 6;

  logic clk;
  logic rst;

  line_buffer_5x5_if #(.DATA_WIDTH(DW), .COLS(COLS), .ROWS(ROWS)) bus ();

  line_buffer_5x5 #(.DATA_WIDTH(DW), .COLS(COLS), .ROWS(ROWS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: the frame as an image array plus a raster position.
  logic [7:0] img [ROWS][COLS];
  int         mr, mc;
  bit         done_pend;
  logic       exp_valid, exp_done;
  logic [2:0] exp_col, exp_row;
  logic [7:0] exp_tap [5];
  bit         tap_known [5];
  int         out_r, out_c;
  int         nvalid, ndone;

  function automatic logic [47:0] obs_vec();
    return {bus.o_valid, bus.o_done, bus.o_col, bus.o_row,
            bus.o_tap4, bus.o_tap3, bus.o_tap2, bus.o_tap1, bus.o_tap0};
  endfunction

  function automatic logic [47:0] exp_vec();
    return {exp_valid, exp_done, exp_col, exp_row,
            exp_tap[4], exp_tap[3], exp_tap[2], exp_tap[1], exp_tap[0]};
  endfunction

  function automatic logic [47:0] mask_vec();
    logic [47:0] m;
    m = {8'hFF, 40'h0};
    for (int k = 0; k < 5; k++) if (tap_known[k]) m[k*8 +: 8] = 8'hFF;
    return m;
  endfunction

  function automatic logic [7:0] ramp(input int r, input int c);
    return 8'(r * 8 + c);
  endfunction

  task automatic model_reset();
    mr = 0; mc = 0; done_pend = 1'b0;
    exp_valid = 1'b0; exp_done = 1'b0; exp_col = '0; exp_row = '0;
    for (int k = 0; k < 5; k++) begin exp_tap[k] = '0; tap_known[k] = 1'b1; end
  endtask

  // Drive one cycle and advance the reference model to what the outputs
  // should show just after the clock edge.
  task automatic step(input bit v, input logic [7:0] d);
    @(negedge clk);
    bus.i_valid = v;
    bus.i_data  = d;
    @(posedge clk);
    #1;
    exp_done  = done_pend;
    done_pend = 1'b0;
    if (v) begin
      img[mr][mc] = d;
      exp_col   = 3'(mc);
      exp_row   = 3'(mr);
      exp_valid = (mr >= 4);
      exp_tap[0] = d;
      tap_known[0] = 1'b1;
      for (int k = 1; k < 5; k++) begin
        if (mr >= k) begin exp_tap[k] = img[mr-k][mc]; tap_known[k] = 1'b1; end
        else tap_known[k] = 1'b0;
      end
      out_r = mr; out_c = mc;
      mc++;
      if (mc == COLS) begin
        mc = 0; mr++;
        if (mr == ROWS) begin mr = 0; done_pend = 1'b1; end
      end
    end else begin
      exp_valid = 1'b0;
    end
    if (bus.o_valid) nvalid++;
    if (bus.o_done) ndone++;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rst = 1'b0; bus.i_valid = 1'b1; bus.i_data = 8'hA5;
      model_reset();
      @(posedge clk); #1;
      vectors++;
      if (obs_vec() !== 48'h0) begin
        miscompares++;
        $display("FAIL reset: outputs %h required %h", obs_vec(), 48'h0);
      end
    end
    @(negedge clk);
    rst = 1'b1; bus.i_valid = 1'b0;
  endtask

  task automatic test_fill_stream();
    nvalid = 0; ndone = 0;
    for (int i = 0; i < ROWS * COLS; i++) begin
      step(1'b1, ramp(i / COLS, i % COLS));
      vectors++;
      if ((obs_vec() & mask_vec()) !== (exp_vec() & mask_vec())) begin
        miscompares++;
        $display("FAIL fill_stream px(%0d,%0d): got %h expected %h", out_r, out_c, obs_vec(), exp_vec());
      end
      if (out_r == 4 && out_c == 3) begin
        vectors++;
        if ({bus.o_tap0, bus.o_tap1, bus.o_tap2, bus.o_tap3, bus.o_tap4} !== {8'd35, 8'd27, 8'd19, 8'd11, 8'd3}) begin
          miscompares++;
          $display("FAIL align_4_3: got %h%h%h%h%h required 231b130b03",
                   bus.o_tap0, bus.o_tap1, bus.o_tap2, bus.o_tap3, bus.o_tap4);
        end
      end
      if (out_r == 5 && out_c == 7) begin
        vectors++;
        if ({bus.o_tap0, bus.o_tap1, bus.o_tap2, bus.o_tap3, bus.o_tap4} !== {8'd47, 8'd39, 8'd31, 8'd23, 8'd15}) begin
          miscompares++;
          $display("FAIL align_5_7: got %h%h%h%h%h required 2f271f170f",
                   bus.o_tap0, bus.o_tap1, bus.o_tap2, bus.o_tap3, bus.o_tap4);
        end
      end
      if (i < 32) begin
        vectors++;
        if (bus.o_valid !== 1'b0 || bus.o_done !== 1'b0) begin
          miscompares++;
          $display("FAIL fill_quiet px %0d: valid %b done %b required 0 0", i, bus.o_valid, bus.o_done);
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'h00);
      vectors++;
      if ((obs_vec() & mask_vec()) !== (exp_vec() & mask_vec())) begin
        miscompares++;
        $display("FAIL frame_end idle %0d: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
    vectors++;
    if ({bus.o_col, bus.o_row} !== {3'd7, 3'd5}) begin
      miscompares++;
      $display("FAIL frame_end_hold: col/row %0d/%0d required 7/5", bus.o_col, bus.o_row);
    end
    vectors++;
    if (nvalid !== 16 || ndone !== 1) begin
      miscompares++;
      $display("FAIL frame_counts: valid %0d done %0d required 16 1", nvalid, ndone);
    end
  endtask

  task automatic test_gapped();
    nvalid = 0; ndone = 0;
    for (int i = 0; i < 2 * ROWS * COLS + 4; i++) begin
      step((i % 2 == 0) && (i < 2 * ROWS * COLS), 8'($urandom_range(0, 255)));
      vectors++;
      if ((obs_vec() & mask_vec()) !== (exp_vec() & mask_vec())) begin
        miscompares++;
        $display("FAIL gapped cyc %0d px(%0d,%0d): got %h expected %h", i, out_r, out_c, obs_vec(), exp_vec());
      end
    end
    vectors++;
    if (nvalid !== 16 || ndone !== 1) begin
      miscompares++;
      $display("FAIL gapped_counts: valid %0d done %0d required 16 1", nvalid, ndone);
    end
  endtask

  task automatic test_back_to_back();
    bit seen_first;
    seen_first = 1'b0;
    nvalid = 0; ndone = 0;
    for (int i = 0; i < 2 * ROWS * COLS; i++) begin
      step(1'b1, ramp((i / COLS) % ROWS, i % COLS));
      vectors++;
      if ((obs_vec() & mask_vec()) !== (exp_vec() & mask_vec())) begin
        miscompares++;
        $display("FAIL back_to_back px %0d: got %h expected %h", i, obs_vec(), exp_vec());
      end
      if (i >= ROWS * COLS && bus.o_valid && !seen_first) begin
        seen_first = 1'b1;
        vectors++;
        if ({bus.o_row, bus.o_col, bus.o_tap0, bus.o_tap1, bus.o_tap2, bus.o_tap3, bus.o_tap4} !==
            {3'd4, 3'd0, 8'd32, 8'd24, 8'd16, 8'd8, 8'd0}) begin
          miscompares++;
          $display("FAIL frame2_first: row %0d col %0d taps %h %h %h %h %h required 4 0 20 18 10 08 00",
                   bus.o_row, bus.o_col, bus.o_tap0, bus.o_tap1, bus.o_tap2, bus.o_tap3, bus.o_tap4);
        end
      end
    end
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00);
    vectors++;
    if (nvalid !== 32 || ndone !== 2 || !seen_first) begin
      miscompares++;
      $display("FAIL b2b_counts: valid %0d done %0d seen %0b required 32 2 1", nvalid, ndone, seen_first);
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 4 * COLS + 2; i++) step(1'b1, ramp(i / COLS, i % COLS));
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      rst = 1'b0; bus.i_valid = 1'b1; bus.i_data = ramp(4, 2);
      model_reset();
      @(posedge clk); #1;
      vectors++;
      if (obs_vec() !== 48'h0) begin
        miscompares++;
        $display("FAIL mid_reset hold %0d: outputs %h required %h", i, obs_vec(), 48'h0);
      end
    end
    @(negedge clk);
    rst = 1'b1; bus.i_valid = 1'b0;
    nvalid = 0; ndone = 0;
    for (int i = 0; i < ROWS * COLS + 2; i++) begin
      step(i < ROWS * COLS, 8'($urandom_range(0, 255)));
      vectors++;
      if ((obs_vec() & mask_vec()) !== (exp_vec() & mask_vec())) begin
        miscompares++;
        $display("FAIL mid_reset restart cyc %0d: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
    vectors++;
    if (nvalid !== 16 || ndone !== 1) begin
      miscompares++;
      $display("FAIL mid_reset_counts: valid %0d done %0d required 16 1", nvalid, ndone);
    end
  endtask

  task automatic test_random();
    int accepted;
    int cyc;
    bit v;
    accepted = 0; cyc = 0;
    nvalid = 0; ndone = 0;
    while (accepted < 2 * ROWS * COLS && cyc < 2000) begin
      v = ($urandom_range(0, 3) != 0);
      step(v, 8'($urandom_range(0, 255)));
      if (v) accepted++;
      cyc++;
      vectors++;
      if ((obs_vec() & mask_vec()) !== (exp_vec() & mask_vec())) begin
        miscompares++;
        $display("FAIL random cyc %0d: got %h expected %h", cyc, obs_vec(), exp_vec());
      end
    end
    for (int i = 0; i < 2; i++) step(1'b0, 8'h00);
    vectors++;
    if (accepted != 2 * ROWS * COLS || nvalid !== 32 || ndone !== 2) begin
      miscompares++;
      $display("FAIL random_counts: accepted %0d valid %0d done %0d required 96 32 2", accepted, nvalid, ndone);
    end
  endtask

  initial begin
    rst = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_data = '0;
    model_reset();
    for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) img[r][c] = '0;
    test_reset();
    test_fill_stream();
    test_gapped();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
